rv_fetch_unit: RTL and testbench
================================

# rv_fetch_unit

Instruction-fetch stage of the pipelined RV32I core. Holds the architectural fetch PC, issues single-outstanding requests to instruction memory, and presents the fetched word to the branch unit in IF. Consumes the branch unit's next-PC select, PC-adder offset, prediction and flush, and loads the IF/ID pipeline register under ID stall/flush control.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- i_fu_clk  in  1  core clock
- i_fu_rst  in  1  reset; synchronous, active-high
- i_fu_pc_next_sel  in  rv_pkg::pc_next_sel_e  PC_ADDER_RES_IF / PC_PLUS_4_EX / ALU_RES_EX
- i_fu_pc_adder_src  in  XLEN  offset added to IF PC (4 or B/J immediate)
- i_fu_pred_taken  in  1  prediction for instr in IF
- i_fu_pc_plus_4_ex  in  XLEN  EX-stage PC+4
- i_fu_alu_res_ex  in  XLEN  EX-stage branch/jalr target
- i_fu_ifid_flush  in  1  redirect from EX; kills IF and IF/ID
- i_fu_id_stall  in  1  ID cannot accept
- o_fu_imem_req  out  1  fetch request
- o_fu_imem_addr  out  XLEN  fetch address
- i_fu_imem_gnt  in  1  request accepted this cycle
- i_fu_imem_rvalid  in  1  response valid
- i_fu_imem_rdata  in  32  response word
- o_fu_instr_if  out  32  instr held in IF (to branch unit)
- o_fu_ifid_valid / o_fu_ifid_instr / o_fu_ifid_pc / o_fu_ifid_pc_plus_4 / o_fu_ifid_pred_taken  out  1/32/XLEN/XLEN/1  IF/ID register
- o_fu_misalign  out  1  sticky misaligned-target flag

## Operation
- States: FETCH (req=1, addr=PC), WAIT (granted, await rvalid), HAVE (word in IF hold reg), DRAIN (await and discard stale response), HALT (macro only).
- FETCH: gnt -> WAIT. gnt=0 -> stay; addr held stable unless redirected.
- WAIT: rvalid -> capture rdata into IF hold reg, -> HAVE.
- HAVE: o_fu_instr_if = hold reg. If !stall: IF/ID <= {1, instr, PC, PC+4, pred_taken}; PC <= next PC; req asserted combinationally with addr = next PC in the same cycle; gnt -> WAIT else -> FETCH. If stall: hold everything; IF/ID unchanged.
- Outside HAVE, o_fu_instr_if = 32'h0000_0013 (NOP) so the branch unit sees no branch/jal.
- Next PC (sel): PC_ADDER_RES_IF -> PC + i_fu_pc_adder_src (mod 2^XLEN, wraps); PC_PLUS_4_EX -> i_fu_pc_plus_4_ex; ALU_RES_EX -> i_fu_alu_res_ex.
- Flush (any state): PC <= EX target selected by sel; IF hold invalidated; IF/ID valid <= 0 (other IF/ID fields unchanged). Next state: FETCH if no response outstanding; DRAIN if in WAIT without rvalid this cycle, or in FETCH with gnt this cycle. rvalid coinciding with flush in WAIT is discarded, -> FETCH.
- DRAIN: req=0; rvalid -> FETCH. Further flush in DRAIN only updates PC.
- Stall without HAVE: IF/ID holds; fetch proceeds up to HAVE.
- Priority: reset > flush > stall > advance.
- When not stalled and nothing advances, o_fu_ifid_valid <= 0 (bubble).

## Timing
- Reset: PC=RESET_PC, state FETCH, req=0 during reset, all IF/ID outputs 0, o_fu_instr_if=NOP, o_fu_misalign=0. First req in the first cycle after reset deasserts.
- Zero-wait memory (gnt same cycle, rvalid next cycle): one instruction per 2 cycles into IF/ID.
- Flush -> new target on o_fu_imem_addr next cycle (FETCH) or one cycle after the stale rvalid (DRAIN).
- At most one request outstanding; req never asserted in WAIT, DRAIN or HALT.

## Configuration
- RV_FETCH_MISALIGN_CHK_EN defined: a next PC with bits[1:0]!=0 sets o_fu_misalign (sticky until reset), PC not loaded, state -> HALT (or DRAIN then HALT if a response is outstanding); no further requests.
- Undefined: o_fu_imem_addr[1:0] forced to 2'b00, PC keeps full value, o_fu_misalign tied 0, HALT absent.

## Test plan
- Reset release, zero-wait memory returning 0x00000013: addr 0,4,8 issued every 2 cycles; IF/ID pc 0,4,8, valid=1.
- Predicted-taken branch at 0x10 (adder_src=0x40, pred=1): next addr 0x50, IF/ID pc=0x10, pred_taken=1.
- Flush with sel=ALU_RES_EX, target 0x200, while in WAIT: stale rvalid dropped, IF/ID valid=0, next req addr=0x200.
- id_stall held 3 cycles in HAVE: IF/ID and req unchanged; on release IF/ID loads held instr, PC advances by 4.
- Flush and stall same cycle in HAVE: flush wins, IF/ID valid=0, PC=target.
- Macro on, sel=ALU_RES_EX target 0x102: o_fu_misalign=1, req stays 0 until reset; macro off: addr 0x100.

Source files
------------

// File: rtl/rv_fetch_unit.sv
// RV32I instruction-fetch stage: fetch PC, single-outstanding imem requests, IF hold register, IF/ID register.
// Optional build macro RV_FETCH_MISALIGN_CHK_EN: trap misaligned next-PC into a sticky flag and HALT.
//
// state   | meaning
// FETCH   | request asserted at PC, waiting for grant
// WAIT    | request granted, waiting for rvalid
// HAVE    | fetched word held in IF, waiting to move into IF/ID
// DRAIN   | flushed with a response outstanding; discard it
// HALT    | misaligned next PC seen; no further requests (macro build only)
module rv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_fu_clk,
  input  logic            i_fu_rst,
  input  logic [1:0]      i_fu_pc_next_sel,
  input  logic [XLEN-1:0] i_fu_pc_adder_src,
  input  logic            i_fu_pred_taken,
  input  logic [XLEN-1:0] i_fu_pc_plus_4_ex,
  input  logic [XLEN-1:0] i_fu_alu_res_ex,
  input  logic            i_fu_ifid_flush,
  input  logic            i_fu_id_stall,
  output logic            o_fu_imem_req,
  output logic [XLEN-1:0] o_fu_imem_addr,
  input  logic            i_fu_imem_gnt,
  input  logic            i_fu_imem_rvalid,
  input  logic [31:0]     i_fu_imem_rdata,
  output logic [31:0]     o_fu_instr_if,
  output logic            o_fu_ifid_valid,
  output logic [31:0]     o_fu_ifid_instr,
  output logic [XLEN-1:0] o_fu_ifid_pc,
  output logic [XLEN-1:0] o_fu_ifid_pc_plus_4,
  output logic            o_fu_ifid_pred_taken,
  output logic            o_fu_misalign
);

  localparam logic [1:0]  PC_ADDER_RES_IF = 2'd0;
  localparam logic [1:0]  PC_PLUS_4_EX    = 2'd1;
  localparam logic [1:0]  ALU_RES_EX      = 2'd2;
  localparam logic [31:0] NOP             = 32'h0000_0013;

`ifdef RV_FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HAVE, S_DRAIN, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HAVE, S_DRAIN} state_e;
`endif

  state_e          state;
  state_e          idle_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] addr_raw;
  logic [31:0]     hold;
  logic            advance;
  logic            redirect;
  logic            bad;

  always_comb begin
    case (i_fu_pc_next_sel)
      PC_ADDER_RES_IF: pc_nxt = pc + i_fu_pc_adder_src;
      PC_PLUS_4_EX:    pc_nxt = i_fu_pc_plus_4_ex;
      ALU_RES_EX:      pc_nxt = i_fu_alu_res_ex;
      default:         pc_nxt = i_fu_alu_res_ex;
    endcase
  end

  assign advance  = (state == S_HAVE) && !i_fu_ifid_flush && !i_fu_id_stall;
  assign redirect = i_fu_ifid_flush || advance;

`ifdef RV_FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign bad           = redirect && (pc_nxt[1:0] != 2'b00);
  // once misaligned, every exit from a request-idle point lands in HALT
  assign idle_state    = (misalign_q || bad) ? S_HALT : S_FETCH;
  assign o_fu_misalign = misalign_q;
`else
  assign bad           = 1'b0;
  assign idle_state    = S_FETCH;
  assign o_fu_misalign = 1'b0;
`endif

  // In HAVE the next request goes out in the same cycle the word moves to IF/ID.
  always_comb begin
    o_fu_imem_req = 1'b0;
    addr_raw      = advance ? pc_nxt : pc;
    if (!i_fu_rst) begin
      if (state == S_FETCH)
        o_fu_imem_req = 1'b1;
      else if (advance && !bad)
        o_fu_imem_req = 1'b1;
    end
  end

`ifdef RV_FETCH_MISALIGN_CHK_EN
  assign o_fu_imem_addr = addr_raw;
`else
  assign o_fu_imem_addr = addr_raw & {{(XLEN-2){1'b1}}, 2'b00};
`endif

  assign o_fu_instr_if = (state == S_HAVE) ? hold : NOP;

  always_ff @(posedge i_fu_clk) begin
    if (i_fu_rst) begin
      state                <= S_FETCH;
      pc                   <= RESET_PC;
      hold                 <= '0;
      o_fu_ifid_valid      <= 1'b0;
      o_fu_ifid_instr      <= '0;
      o_fu_ifid_pc         <= '0;
      o_fu_ifid_pc_plus_4  <= '0;
      o_fu_ifid_pred_taken <= 1'b0;
`ifdef RV_FETCH_MISALIGN_CHK_EN
      misalign_q           <= 1'b0;
`endif
    end else begin
      if (redirect && !bad)
        pc <= pc_nxt;
`ifdef RV_FETCH_MISALIGN_CHK_EN
      if (bad)
        misalign_q <= 1'b1;
`endif
      if (i_fu_ifid_flush) begin
        o_fu_ifid_valid <= 1'b0;
      end else if (advance) begin
        o_fu_ifid_valid      <= 1'b1;
        o_fu_ifid_instr      <= hold;
        o_fu_ifid_pc         <= pc;
        o_fu_ifid_pc_plus_4  <= pc + XLEN'(4);
        o_fu_ifid_pred_taken <= i_fu_pred_taken;
      end else if (!i_fu_id_stall) begin
        o_fu_ifid_valid <= 1'b0;
      end

      case (state)
        S_FETCH: begin
          if (i_fu_imem_gnt)
            state <= i_fu_ifid_flush ? S_DRAIN : S_WAIT;
          else if (i_fu_ifid_flush)
            state <= idle_state;
        end
        S_WAIT: begin
          if (i_fu_ifid_flush) begin
            state <= i_fu_imem_rvalid ? idle_state : S_DRAIN;
          end else if (i_fu_imem_rvalid) begin
            hold  <= i_fu_imem_rdata;
            state <= S_HAVE;
          end
        end
        S_HAVE: begin
          if (i_fu_ifid_flush)
            state <= idle_state;
          else if (advance)
            state <= (i_fu_imem_gnt && !bad) ? S_WAIT : idle_state;
        end
        S_DRAIN: begin
          if (i_fu_imem_rvalid)
            state <= idle_state;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed self-checking bench for rv_fetch_unit; expectations follow RV_FETCH_MISALIGN_CHK_EN when defined.
module tb_rv_fetch_unit;
  localparam logic [1:0]  SEL_ADD  = 2'd0;
  localparam logic [1:0]  SEL_P4   = 2'd1;
  localparam logic [1:0]  SEL_ALU  = 2'd2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [31:0] adder_src, pc_plus_4_ex, alu_res_ex;
  logic        pred_taken, flush, stall;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata, instr_if;
  logic        ifid_valid, ifid_pred, misalign;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        auto_mem;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  rv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .i_fu_clk(clk), .i_fu_rst(rst), .i_fu_pc_next_sel(sel),
    .i_fu_pc_adder_src(adder_src), .i_fu_pred_taken(pred_taken),
    .i_fu_pc_plus_4_ex(pc_plus_4_ex), .i_fu_alu_res_ex(alu_res_ex),
    .i_fu_ifid_flush(flush), .i_fu_id_stall(stall),
    .o_fu_imem_req(req), .o_fu_imem_addr(addr), .i_fu_imem_gnt(gnt),
    .i_fu_imem_rvalid(rvalid), .i_fu_imem_rdata(rdata),
    .o_fu_instr_if(instr_if), .o_fu_ifid_valid(ifid_valid),
    .o_fu_ifid_instr(ifid_instr), .o_fu_ifid_pc(ifid_pc),
    .o_fu_ifid_pc_plus_4(ifid_pc4), .o_fu_ifid_pred_taken(ifid_pred),
    .o_fu_misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one clock; a zero-wait memory answers a granted request on the next edge
  task automatic step();
    logic issued;
    issued = req & gnt;
    @(posedge clk);
    #1;
    if (auto_mem) rvalid = issued;
  endtask

  initial begin
    rst = 1'b1; sel = SEL_ADD; adder_src = 32'd4; pred_taken = 1'b0;
    pc_plus_4_ex = '0; alu_res_ex = '0; flush = 1'b0; stall = 1'b0;
    gnt = 1'b1; rvalid = 1'b0; rdata = NOP; auto_mem = 1'b1;
    repeat (3) step();
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_instr_if", instr_if, NOP);
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_pc4", ifid_pc4, 32'd0);
    chk("rst_ifid_pred", {31'b0, ifid_pred}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);

    rst = 1'b0; gnt = 1'b0; #1;
    chk("first_req", {31'b0, req}, 32'd1);
    chk("first_addr", addr, 32'h0);
    step();
    chk("nogrant_req", {31'b0, req}, 32'd1);
    chk("nogrant_addr", addr, 32'h0);
    gnt = 1'b1;
    step();
    chk("wait_req", {31'b0, req}, 32'd0);
    step();
    chk("have_instr_if", instr_if, NOP);
    chk("addr_4", addr, 32'h4);
    chk("addr_4_req", {31'b0, req}, 32'd1);
    step();
    chk("ifid0_valid", {31'b0, ifid_valid}, 32'd1);
    chk("ifid0_pc", ifid_pc, 32'h0);
    chk("ifid0_pc4", ifid_pc4, 32'h4);
    step();
    chk("bubble_valid", {31'b0, ifid_valid}, 32'd0);
    chk("addr_8", addr, 32'h8);
    step();
    chk("ifid1_pc", ifid_pc, 32'h4);
    step();
    step();
    chk("ifid2_pc", ifid_pc, 32'h8);
    repeat (3) step();

    // predicted-taken branch at 0x10
    adder_src = 32'h40; pred_taken = 1'b1; #1;
    chk("br_addr", addr, 32'h50);
    step();
    adder_src = 32'd4; pred_taken = 1'b0;
    chk("br_ifid_pc", ifid_pc, 32'h10);
    chk("br_ifid_pred", {31'b0, ifid_pred}, 32'd1);
    chk("br_ifid_pc4", ifid_pc4, 32'h14);

    // flush in WAIT with coinciding rvalid
    flush = 1'b1; sel = SEL_ALU; alu_res_ex = 32'h200;
    step();
    flush = 1'b0; sel = SEL_ADD; #1;
    chk("fl_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("fl_addr", addr, 32'h200);
    chk("fl_req", {31'b0, req}, 32'd1);
    chk("fl_instr_if", instr_if, NOP);

    // flush in WAIT before the response: DRAIN drops the stale word
    auto_mem = 1'b0;
    step();
    chk("dr_wait_req", {31'b0, req}, 32'd0);
    flush = 1'b1; sel = SEL_ALU; alu_res_ex = 32'h300;
    step();
    flush = 1'b0; sel = SEL_ADD; #1;
    chk("drain_req0", {31'b0, req}, 32'd0);
    chk("drain_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    step();
    chk("drain_req1", {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0; rdata = 32'h00A0_0093; auto_mem = 1'b1;
    chk("drain_addr", addr, 32'h300);
    chk("drain_exit_req", {31'b0, req}, 32'd1);
    chk("drain_instr_if", instr_if, NOP);
    step();
    step();

    // ID stall held three cycles in HAVE
    stall = 1'b1; #1;
    chk("stall_req", {31'b0, req}, 32'd0);
    chk("stall_instr_if", instr_if, 32'h00A0_0093);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_req", {31'b0, req}, 32'd0);
      chk("stall_hold_instr_if", instr_if, 32'h00A0_0093);
      chk("stall_hold_ifid_pc", ifid_pc, 32'h10);
      chk("stall_hold_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    end
    stall = 1'b0; #1;
    chk("unstall_addr", addr, 32'h304);
    chk("unstall_req", {31'b0, req}, 32'd1);
    step();
    chk("unstall_ifid_valid", {31'b0, ifid_valid}, 32'd1);
    chk("unstall_ifid_instr", ifid_instr, 32'h00A0_0093);
    chk("unstall_ifid_pc", ifid_pc, 32'h300);
    chk("unstall_ifid_pc4", ifid_pc4, 32'h304);
    rdata = NOP;
    step();

    // flush and stall together in HAVE: flush wins
    stall = 1'b1; flush = 1'b1; sel = SEL_P4; pc_plus_4_ex = 32'h400; #1;
    chk("fs_req", {31'b0, req}, 32'd0);
    step();
    stall = 1'b0; flush = 1'b0; sel = SEL_ADD; #1;
    chk("fs_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("fs_addr", addr, 32'h400);
    chk("fs_ifid_pc", ifid_pc, 32'h300);
    step();
    step();

    // misaligned redirect to 0x102
    flush = 1'b1; sel = SEL_ALU; alu_res_ex = 32'h102;
    step();
    flush = 1'b0; sel = SEL_ADD; #1;
`ifdef RV_FETCH_MISALIGN_CHK_EN
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_req", {31'b0, req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_req", {31'b0, req}, 32'd0);
      chk("halt_flag", {31'b0, misalign}, 32'd1);
      chk("halt_instr_if", instr_if, NOP);
    end
`else
    chk("mis_addr", addr, 32'h100);
    chk("mis_req", {31'b0, req}, 32'd1);
    chk("mis_flag", {31'b0, misalign}, 32'd0);
    step();
    step();
    chk("mis_next_addr", addr, 32'h104);
    step();
    chk("mis_ifid_pc", ifid_pc, 32'h102);
`endif

    rst = 1'b1;
    step();
    step();
    chk("rst2_misalign", {31'b0, misalign}, 32'd0);
    chk("rst2_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    rst = 1'b0; #1;
    chk("rst2_addr", addr, 32'h0);
    chk("rst2_req", {31'b0, req}, 32'd1);

    // PC adder wraps modulo 2^32
    step();
    step();
    flush = 1'b1; sel = SEL_ALU; alu_res_ex = 32'hFFFF_FFFC;
    step();
    flush = 1'b0; sel = SEL_ADD; #1;
    chk("wrap_fetch_addr", addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wrap_addr", addr, 32'h0);
    step();
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_ifid_pc4", ifid_pc4, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
